// File: rtl/display_arb_pkg.sv
// Shared constants and types for the display arbiter slice.
package display_arb_pkg;

  localparam int unsigned NREQ = 3;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } state_t;

  // After reset the pointer sits on the last requester so requester 0 wins first.
  localparam logic [1:0] LAST_RESET = 2'd2;

  // One-hot (or zero) requester vector to its index; zero maps to 0.
  function automatic logic [1:0] onehot_idx(input logic [NREQ-1:0] oh);
    if (oh[2]) return 2'd2;
    if (oh[1]) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin pick among three requesters, searching from last+1.
module rr_pick3
  import display_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  // First pending requester in the order last+1, last+2, last (mod 3).
  always_comb begin : pick
    logic [1:0] idx;
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 2'((32'(last) + k) % NREQ);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates three requesters for one seven-segment display with a minimum dwell.
module display_arbiter
  import display_arb_pkg::*;
#(
  parameter int W     = 32,
  parameter int DWELL = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   num_in,
  input  logic [NREQ*8-1:0]   dots_in,
  output logic [NREQ-1:0]     grant,
  output logic [W-1:0]        num,
  output logic [7:0]          dots,
  output logic                busy
);

  localparam logic [7:0] DWELL_C = 8'(DWELL);

  state_t          state;
  logic [7:0]      cnt;
  logic [1:0]      last;
  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] win;
  logic            win_valid;
  logic [1:0]      win_idx;
  logic [1:0]      own_idx;

  // Masking the current owner means one picker serves both IDLE and HOLD:
  // in IDLE grant is zero, in HOLD only the other requesters compete.
  assign pick_req = req & ~grant;
  assign win_idx  = onehot_idx(win);
  assign own_idx  = onehot_idx(grant);
  assign busy     = |grant;

  rr_pick3 u_pick (
    .req   (pick_req),
    .last  (last),
    .win   (win),
    .valid (win_valid)
  );

  // Grant FSM with dwell counter; num/dots always track the granted owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
      num   <= '0;
      dots  <= '0;
      cnt   <= '0;
      last  <= LAST_RESET;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state <= ST_HOLD;
            grant <= win;
            last  <= win_idx;
            cnt   <= '0;
            num   <= num_in[win_idx*W +: W];
            dots  <= dots_in[win_idx*8 +: 8];
          end else begin
            grant <= '0;
            num   <= '0;
            dots  <= '0;
          end
        end
        ST_HOLD: begin
          if ((req & grant) == '0) begin
            // Owner release wins over dwell expiry.
            state <= ST_IDLE;
            grant <= '0;
            num   <= '0;
            dots  <= '0;
            cnt   <= '0;
            last  <= own_idx;
          end else if (cnt == DWELL_C && win_valid) begin
            grant <= win;
            last  <= win_idx;
            cnt   <= '0;
            num   <= num_in[win_idx*W +: W];
            dots  <= dots_in[win_idx*8 +: 8];
          end else begin
            if (en && cnt != DWELL_C) cnt <= cnt + 8'd1;
            num  <= num_in[own_idx*W +: W];
            dots <= dots_in[own_idx*8 +: 8];
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: vector table, corner sequences, random run vs model.
module tb_display_arbiter;

  localparam int W     = 32;
  localparam int DWELL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    req;
  logic [3*W-1:0] num_in;
  logic [23:0]   dots_in;
  logic [2:0]    grant;
  logic [W-1:0]  num;
  logic [7:0]    dots;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: owner index (-1 idle), dwell count, last owner, output regs.
  int            m_owner;
  int            m_cnt;
  int            m_last;
  logic [W-1:0]  m_num;
  logic [7:0]    m_dots;

  display_arbiter #(.W(W), .DWELL(DWELL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .num_in  (num_in),
    .dots_in (dots_in),
    .grant   (grant),
    .num     (num),
    .dots    (dots),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic int rr_next(input logic [2:0] r, input int from);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (from + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] m_grant();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  task automatic model_edge();
    int nxt;
    logic [2:0] others;
    if (!rst_n) begin
      m_owner = -1; m_cnt = 0; m_last = 2; m_num = '0; m_dots = '0;
    end else if (m_owner < 0) begin
      nxt = rr_next(req, m_last);
      if (nxt >= 0) begin
        m_owner = nxt; m_last = nxt; m_cnt = 0;
      end
    end else if (!req[m_owner]) begin
      m_last = m_owner; m_owner = -1; m_cnt = 0;
    end else begin
      others = req & ~(3'(1 << m_owner));
      if (m_cnt == DWELL && others != 0) begin
        nxt = rr_next(others, m_owner);
        m_owner = nxt; m_last = nxt; m_cnt = 0;
      end else if (en && m_cnt < DWELL) begin
        m_cnt++;
      end
    end
    if (rst_n) begin
      m_num  = (m_owner < 0) ? '0 : num_in[m_owner*W +: W];
      m_dots = (m_owner < 0) ? '0 : dots_in[m_owner*8 +: 8];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] eg,
                       input logic [W-1:0] en_num, input logic [7:0] ed);
    vectors++;
    if (grant !== eg || num !== en_num || dots !== ed || busy !== (|eg) ||
        !$onehot0(grant) || busy !== (|grant)) begin
      miscompares++;
      $display("FAIL %s: got grant=%b num=%h dots=%h busy=%b, expected grant=%b num=%h dots=%h busy=%b",
               name, grant, num, dots, busy, eg, en_num, ed, |eg);
    end
  endtask

  function automatic logic [W-1:0] slice_num(input logic [2:0] g);
    return g[0] ? num_in[0 +: W] : g[1] ? num_in[W +: W] : g[2] ? num_in[2*W +: W] : '0;
  endfunction

  function automatic logic [7:0] slice_dots(input logic [2:0] g);
    return g[0] ? dots_in[0 +: 8] : g[1] ? dots_in[8 +: 8] : g[2] ? dots_in[16 +: 8] : '0;
  endfunction

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [2:0] req;
    logic [2:0] exp_grant;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [2:0] eg;
    rst_n = 1'b0; en = 1'b0; req = '0;
    num_in  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    dots_in = {8'hC3, 8'hB2, 8'hA1};
    m_owner = -1; m_cnt = 0; m_last = 2; m_num = '0; m_dots = '0;

    // Hand-derived vectors, DWELL=4; each row is applied then checked after one edge.
    tbl[0]  = '{1'b0, 1'b1, 3'b111, 3'b000};  // reset ignores req and en
    tbl[1]  = '{1'b1, 1'b0, 3'b111, 3'b001};  // requester 0 wins first
    tbl[2]  = '{1'b1, 1'b1, 3'b111, 3'b001};  // cnt 1
    tbl[3]  = '{1'b1, 1'b1, 3'b111, 3'b001};  // cnt 2
    tbl[4]  = '{1'b1, 1'b0, 3'b111, 3'b001};  // cnt 2
    tbl[5]  = '{1'b1, 1'b1, 3'b111, 3'b001};  // cnt 3
    tbl[6]  = '{1'b1, 1'b1, 3'b111, 3'b001};  // cnt 4, no move yet
    tbl[7]  = '{1'b1, 1'b0, 3'b111, 3'b010};  // dwell reached -> rotate
    tbl[8]  = '{1'b1, 1'b1, 3'b011, 3'b010};  // new owner holds
    tbl[9]  = '{1'b1, 1'b1, 3'b001, 3'b000};  // owner 1 drops early
    tbl[10] = '{1'b1, 1'b0, 3'b101, 3'b100};  // search from 2
    tbl[11] = '{1'b1, 1'b0, 3'b001, 3'b000};  // owner 2 drops
    tbl[12] = '{1'b1, 1'b0, 3'b011, 3'b001};  // search wraps to 0
    tbl[13] = '{1'b0, 1'b1, 3'b111, 3'b000};  // reset mid-HOLD
    tbl[14] = '{1'b1, 1'b0, 3'b000, 3'b000};  // idle
    tbl[15] = '{1'b1, 1'b0, 3'b110, 3'b010};  // pointer reset to 2 -> 1 before 2

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; req = tbl[i].req;
      step();
      check($sformatf("table[%0d]", i), tbl[i].exp_grant,
            slice_num(tbl[i].exp_grant), slice_dots(tbl[i].exp_grant));
    end

    // Live update: owner 0 alone, its number changes and the display follows next clk.
    rst_n = 1'b0; req = '0; en = 1'b0; step();
    check("live_reset", 3'b000, '0, 8'h00);
    rst_n = 1'b1; req = 3'b001; num_in[0 +: W] = 32'h0000_1234; step();
    check("live_grant", 3'b001, 32'h0000_1234, 8'hA1);
    num_in[0 +: W] = 32'h0000_ABCD; step();
    check("live_follow", 3'b001, 32'h0000_ABCD, 8'hA1);
    for (int c = 0; c < 44; c++) begin
      en = (c % 4 == 0); step();
      check("live_saturate", 3'b001, 32'h0000_ABCD, 8'hA1);
    end

    // Late arrival: req[1] rises after one tick, owner 0 keeps grant until dwell is reached.
    rst_n = 1'b0; req = '0; en = 1'b0; step();
    rst_n = 1'b1; req = 3'b001; step();
    check("late_grant", 3'b001, 32'h0000_ABCD, 8'hA1);
    for (int c = 0; c < 16; c++) begin
      en  = (c % 4 == 0);
      req = (c >= 1) ? 3'b011 : 3'b001;
      step();
      eg = (c >= 13) ? 3'b010 : 3'b001;
      check($sformatf("late_arrival[%0d]", c), eg, slice_num(eg), slice_dots(eg));
    end

    // Randomized run against the reference model.
    rst_n = 1'b0; req = '0; en = 1'b0; step();
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      en    = ($urandom_range(0, 3) == 0);
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 3) == 0) num_in = {$urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) dots_in = 24'($urandom());
      step();
      check("random", m_grant(), m_num, m_dots);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter: W, 32, width of the hex number bus driven to the seven-segment driver.
REQ-002 Parameter: DWELL, 8, minimum hold time of a grant, counted in en ticks (legal range 1..255).
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: en  input  1  display strobe tick (one clk wide), the same tick that paces the seven-segment driver.
REQ-006 Port: req  input  3  per-requester display request, level-sensitive.
REQ-007 Port: num_in  input  3*W  requester numbers; requester i at [i*W +: W].
REQ-008 Port: dots_in  input  24  requester dot masks; requester i at [i*8 +: 8].
REQ-009 Port: grant  output  3  one-hot owner of the display, all-zero when idle.
REQ-010 Port: num  output  W  registered number for the seven-segment driver.
REQ-011 Port: dots  output  8  registered dot mask for the seven-segment driver.
REQ-012 Port: busy  output  1  high whenever grant is non-zero.

Function
REQ-013 The block SHALL implement two states, IDLE and HOLD, plus a dwell counter of 8 bits and a 2-bit last-owner pointer.
REQ-014 IDLE: when req is non-zero, the block SHALL assert grant to one requester on the next edge and enter HOLD with the dwell counter cleared.
REQ-015 Selection SHALL be round-robin: search order starts at last-owner+1 mod 3 and wraps through 0,1,2.
REQ-016 In HOLD, the dwell counter SHALL increment on each en tick and saturate at DWELL.
REQ-017 In HOLD, while grant is non-zero, num and dots SHALL be registered from the owner's slice every clk (one-cycle latency, live update).
REQ-018 In IDLE, num and dots SHALL be registered as zero.
REQ-019 The grant edge SHALL load num/dots from the new owner in the same edge that asserts grant (no cycle of stale data).
REQ-020 Owner drops req in HOLD: grant SHALL be released on the next edge regardless of dwell, last-owner updated, state to IDLE.
REQ-021 Dwell reached (counter == DWELL) and another requester pending: grant SHALL move to the round-robin winner on the next edge, counter cleared, state stays HOLD.
REQ-022 Dwell reached and no other requester pending: owner SHALL retain grant, counter held at DWELL.
REQ-023 A new requester arriving while counter < DWELL SHALL NOT preempt the owner.
REQ-024 Owner drop and dwell expiry in the same cycle: REQ-020 SHALL take precedence (go to IDLE; re-arbitrate from IDLE next cycle).
REQ-025 grant SHALL never have more than one bit set; busy SHALL equal the OR of grant.

Reset
REQ-026 With rst_n low at a clk edge: state IDLE, grant 0, num 0, dots 0, busy 0, counter 0, last-owner 2 (so requester 0 wins first).
REQ-027 Reset asserted mid-HOLD SHALL drop grant on that edge; req values are ignored while rst_n is low.
REQ-028 en ticks during reset SHALL have no effect.

Structure
REQ-029 State encoding and the requester count (3) SHALL be defined as constants in a shared package, display_arb_pkg.
REQ-030 Round-robin selection SHALL be one sub-module, rr_pick3 (combinational: req, last-owner -> one-hot winner, valid).
REQ-031 Expected RTL size 120-250 lines including rr_pick3.

Verification (W=32, DWELL=4, en every 4 clk)
REQ-032 Reset then req=3'b111 -> grant=001 one edge later, num=num_in[31:0]; after 4 en ticks grant=010, then 100, then 001.
REQ-033 Owner 0 alone with num_in[31:0] changing 0x1234->0xABCD -> num follows one clk later; grant stays 001 past 10 en ticks.
REQ-034 Owner 0 holds, req[1] rises after 1 tick -> grant stays 001 until counter==4, then 010 on next edge.
REQ-035 Owner 1 drops req after 2 ticks -> grant=000, num=0, busy=0 next edge; req[2] pending -> grant=100 one edge later.
REQ-036 rst_n low during HOLD with req=111 -> grant=000, num=0 on that edge; after release req=111 -> grant=001.
REQ-037 All runs: assertion that grant is one-hot-or-zero and busy==|grant every cycle.
